// File: rtl/btn_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, 4-state debounce FSM, and
// registered level plus press / release / long-press strobes.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    // Pin level that means "not pressed"; the synchroniser resets to it.
    localparam logic IDLE_PIN = ACTIVE_LOW;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic                sync1, sync2, act;
    logic [DEB_W-1:0]    deb_cnt, deb_nxt;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic                long_done, long_done_nxt;
    logic                pressed_nxt, press_nxt, release_nxt, long_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= IDLE_PIN;
            sync2 <= IDLE_PIN;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    assign act = ACTIVE_LOW ? ~sync2 : sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RELEASED;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            long_done     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            long_done     <= long_done_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
            long_pulse    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        hold_nxt  = hold_cnt;
        unique case (state)
            RELEASED: begin
                hold_nxt = '0;
                if (act) begin
                    state_nxt = PRESS_CHK;
                    deb_nxt   = DEB_ONE;
                end else begin
                    deb_nxt = '0;
                end
            end
            PRESS_CHK: begin
                if (!act) begin
                    state_nxt = RELEASED;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                end else if (deb_cnt != DEB_MAX) begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end
            PRESSED: begin
                if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + HOLD_ONE;
                if (!act) begin
                    state_nxt = RELEASE_CHK;
                    deb_nxt   = DEB_ONE;
                end else begin
                    deb_nxt = '0;
                end
            end
            RELEASE_CHK: begin
                // Hold time keeps running while a release is still unconfirmed.
                if (hold_cnt != HOLD_MAX) hold_nxt = hold_cnt + HOLD_ONE;
                if (act) begin
                    state_nxt = PRESSED;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = RELEASED;
                    deb_nxt   = '0;
                end else if (deb_cnt != DEB_MAX) begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end
            default: begin
                state_nxt = RELEASED;
                deb_nxt   = '0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pressed_nxt   = (state_nxt == PRESSED) || (state_nxt == RELEASE_CHK);
        press_nxt     = (state == PRESS_CHK) && (state_nxt == PRESSED);
        release_nxt   = (state == RELEASE_CHK) && (state_nxt == RELEASED);
        // A release accepted on the threshold cycle suppresses the long strobe.
        long_nxt      = ((state == PRESSED) || (state == RELEASE_CHK)) &&
                        (hold_cnt == HOLD_LAST) && !long_done && !release_nxt;
        long_done_nxt = long_done;
        if (press_nxt || release_nxt) long_done_nxt = 1'b0;
        else if (long_nxt)            long_done_nxt = 1'b1;
    end

endmodule

// File: tb/tb_btn_debouncer.sv
// Bench for btn_debouncer: an active-low and an active-high instance share one
// stimulus (pin inverted for the latter) and one expected-event scoreboard.
module tb_btn_debouncer;

    localparam int DEB  = 8;
    localparam int LONG = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic btn_hi;
    logic pressed_lo, press_lo, release_lo, long_lo;
    logic pressed_hi, press_hi, release_hi, long_hi;

    assign btn_hi = ~btn;

    always #5 clk = ~clk;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .btn(btn),
        .pressed(pressed_lo), .press_pulse(press_lo),
        .release_pulse(release_lo), .long_pulse(long_lo)
    );

    btn_debouncer #(.DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .btn(btn_hi),
        .pressed(pressed_hi), .press_pulse(press_hi),
        .release_pulse(release_hi), .long_pulse(long_hi)
    );

    typedef struct {
        string name;
        bit    rst;
        bit    btn;
        int    cycles;
        int    press_at;
        int    release_at;
        int    long_at;
    } step_t;

    typedef struct {
        int at;
        bit val;
    } lvl_t;

    int     cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    string  cur = "start";
    int     press_q[$];
    int     release_q[$];
    int     long_q[$];
    lvl_t   lvl_q[$];
    logic   exp_level = 1'b0;
    step_t  tbl[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic step_t mk(input string name, input bit r, input bit b, input int n,
                                 input int p, input int rl, input int lg);
        step_t s;
        s.name = name; s.rst = r; s.btn = b; s.cycles = n;
        s.press_at = p; s.release_at = rl; s.long_at = lg;
        return s;
    endfunction

    task automatic check(input string nm, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s [%s] cycle %0d: got %b, want %b", nm, cur, cyc, got, want);
        end
    endtask

    task automatic check_empty(input string nm, input int left);
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL %s: %0d expected events never seen, want 0", nm, left);
        end
    endtask

    // Offsets are relative to the cycle in which the step's pin/rst levels are driven.
    task automatic run_step(input step_t s);
        int t0;
        t0  = cyc;
        cur = s.name;
        rst = s.rst;
        btn = s.btn;
        if (s.rst) lvl_q.push_back('{t0 + 1, 1'b0});
        if (s.press_at >= 0) begin
            press_q.push_back(t0 + s.press_at);
            lvl_q.push_back('{t0 + s.press_at, 1'b1});
        end
        if (s.release_at >= 0) begin
            release_q.push_back(t0 + s.release_at);
            lvl_q.push_back('{t0 + s.release_at, 1'b0});
        end
        if (s.long_at >= 0) long_q.push_back(t0 + s.long_at);
        repeat (s.cycles) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic e_press, e_release, e_long;
        if (cyc >= 1) begin
            if (lvl_q.size() > 0 && lvl_q[0].at == cyc) begin
                exp_level = lvl_q[0].val;
                void'(lvl_q.pop_front());
            end
            e_press = (press_q.size() > 0 && press_q[0] == cyc);
            if (e_press) void'(press_q.pop_front());
            e_release = (release_q.size() > 0 && release_q[0] == cyc);
            if (e_release) void'(release_q.pop_front());
            e_long = (long_q.size() > 0 && long_q[0] == cyc);
            if (e_long) void'(long_q.pop_front());

            check("pressed_lo", pressed_lo, exp_level);
            check("press_lo",   press_lo,   e_press);
            check("release_lo", release_lo, e_release);
            check("long_lo",    long_lo,    e_long);
            check("pressed_hi", pressed_hi, exp_level);
            check("press_hi",   press_hi,   e_press);
            check("release_hi", release_hi, e_release);
            check("long_hi",    long_hi,    e_long);
        end
    end

    initial begin
        tbl.push_back(mk("reset",               1, 1,  3, -1, -1, -1));
        tbl.push_back(mk("idle",                0, 1,  5, -1, -1, -1));
        tbl.push_back(mk("clean_press_long",    0, 0, 70, 10, -1, 50));
        tbl.push_back(mk("release",             0, 1, 20, -1, 10, -1));
        tbl.push_back(mk("bounce_low5",         0, 0,  5, -1, -1, -1));
        tbl.push_back(mk("bounce_high1",        0, 1,  1, -1, -1, -1));
        tbl.push_back(mk("bounce_final_long",   0, 0, 60, 10, -1, 50));
        tbl.push_back(mk("rel_bounce_high4",    0, 1,  4, -1, -1, -1));
        tbl.push_back(mk("rel_bounce_low",      0, 0, 10, -1, -1, -1));
        tbl.push_back(mk("release2",            0, 1, 20, -1, 10, -1));
        tbl.push_back(mk("tie_press",           0, 0, 40, 10, -1, -1));
        tbl.push_back(mk("tie_release",         0, 1, 20, -1, 10, -1));
        tbl.push_back(mk("relchk_long_press",   0, 0, 45, 10, -1, 50));
        tbl.push_back(mk("relchk_long_release", 0, 1, 20, -1, 10, -1));

        foreach (tbl[i]) run_step(tbl[i]);

        // Reset one cycle before a press would be accepted: strobe dropped,
        // held pin re-accepted 10 cycles after rst falls.
        run_step(mk("pchk_low",   0, 0,  9, -1, -1, -1));
        run_step(mk("pchk_rst",   1, 0,  1, -1, -1, -1));
        run_step(mk("pchk_rearm", 0, 0, 25, 10, -1, -1));

        // Reset while pressed: level drops next cycle, no release strobe.
        run_step(mk("pressed_rst",   1, 0,  1, -1, -1, -1));
        run_step(mk("pressed_rearm", 0, 0, 20, 10, -1, -1));
        run_step(mk("final_release", 0, 1, 20, -1, 10, -1));
        run_step(mk("tail",          0, 1, 10, -1, -1, -1));

        check_empty("press_events_left",   press_q.size());
        check_empty("release_events_left", release_q.size());
        check_empty("long_events_left",    long_q.size());
        check_empty("level_events_left",   lvl_q.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
